sketch_hot_page_filter: RTL and testbench



---
 rtl/sketch_hot_page_filter.sv | 138 +++++++++++++
 tb/tb_sketch_hot_page_filter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sketch_hot_page_filter.sv
// sketch_hot_page_filter: threshold filter with dedup table and show-ahead candidate FIFO; HOT_FILTER_STATS_EN adds cand_cnt/dedup_cnt.
module sketch_hot_page_filter #(
    parameter int ADDR_WIDTH_FULL = 12,
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 8,
    parameter int DEDUP_ENTRIES   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          rd_data_in,
    input  logic [ADDR_WIDTH_FULL-1:0]     rd_addr_in,
    input  logic                           rd_data_valid_in,
    input  logic [DATA_WIDTH-1:0]          threshold,
    input  logic                           dedup_clr,
    output logic [ADDR_WIDTH_FULL-1:0]     hot_addr,
    output logic [DATA_WIDTH-1:0]          hot_cnt,
    output logic                           hot_valid,
    input  logic                           hot_ready,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic [15:0]                    drop_cnt
`ifdef HOT_FILTER_STATS_EN
    ,
    output logic [31:0]                    cand_cnt,
    output logic [15:0]                    dedup_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (DEDUP_ENTRIES > 1) ? $clog2(DEDUP_ENTRIES) : 1;

    logic                       s1_valid_q, s1_valid_d;
    logic [ADDR_WIDTH_FULL-1:0] s1_addr_q, s1_addr_d;
    logic [DATA_WIDTH-1:0]      s1_cnt_q, s1_cnt_d;
    logic [ADDR_WIDTH_FULL-1:0] tbl_addr_q [DEDUP_ENTRIES];
    logic [ADDR_WIDTH_FULL-1:0] tbl_addr_d [DEDUP_ENTRIES];
    logic [DEDUP_ENTRIES-1:0]   tbl_vld_q, tbl_vld_d;
    logic [PW-1:0]              ptr_q, ptr_d;
    logic [ADDR_WIDTH_FULL-1:0] mem_addr_q [FIFO_DEPTH];
    logic [ADDR_WIDTH_FULL-1:0] mem_addr_d [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]      mem_cnt_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]      mem_cnt_d [FIFO_DEPTH];
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]              level_q, level_d;
    logic [15:0]                drop_cnt_q, drop_cnt_d;
    logic                       hit, push, pop, wr;

    assign hot_valid  = level_q != '0;
    assign hot_addr   = hot_valid ? mem_addr_q[rd_ptr_q] : '0;
    assign hot_cnt    = hot_valid ? mem_cnt_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign drop_cnt   = drop_cnt_q;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEDUP_ENTRIES; i++)
            hit = hit | (tbl_vld_q[i] && tbl_addr_q[i] == s1_addr_q);
        push = s1_valid_q && !hit;
        pop  = hot_valid && hot_ready;
        wr   = push && (level_q < LW'(FIFO_DEPTH) || pop);
        s1_valid_d = rd_data_valid_in && threshold != '0 && rd_data_in >= threshold;
        s1_addr_d  = rd_addr_in;
        s1_cnt_d   = rd_data_in;
        mem_addr_d = mem_addr_q;
        mem_cnt_d  = mem_cnt_q;
        if (wr) begin
            mem_addr_d[wr_ptr_q] = s1_addr_q;
            mem_cnt_d[wr_ptr_q]  = s1_cnt_q;
        end
        wr_ptr_d   = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q + LW'(wr) - LW'(pop);
        drop_cnt_d = (push && !wr && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        tbl_addr_d = tbl_addr_q;
        tbl_vld_d  = tbl_vld_q;
        ptr_d      = ptr_q;
        if (wr) begin
            tbl_addr_d[ptr_q] = s1_addr_q;
            tbl_vld_d[ptr_q]  = 1'b1;
            ptr_d = (ptr_q == PW'(DEDUP_ENTRIES - 1)) ? '0 : ptr_q + PW'(1);
        end
        // Clear overrides a same-cycle insertion; the lookup above already used the old table.
        if (dedup_clr) begin
            tbl_vld_d = '0;
            ptr_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            tbl_vld_q  <= '0;
            ptr_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            tbl_vld_q  <= tbl_vld_d;
            ptr_q      <= ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_addr_q  <= s1_addr_d;
        s1_cnt_q   <= s1_cnt_d;
        tbl_addr_q <= tbl_addr_d;
        mem_addr_q <= mem_addr_d;
        mem_cnt_q  <= mem_cnt_d;
    end

`ifdef HOT_FILTER_STATS_EN
    logic [31:0] cand_cnt_q, cand_cnt_d;
    logic [15:0] dedup_cnt_q, dedup_cnt_d;

    assign cand_cnt  = cand_cnt_q;
    assign dedup_cnt = dedup_cnt_q;

    always_comb begin
        cand_cnt_d  = s1_valid_q ? cand_cnt_q + 32'd1 : cand_cnt_q;
        dedup_cnt_d = (s1_valid_q && hit && dedup_cnt_q != 16'hFFFF) ? dedup_cnt_q + 16'd1 : dedup_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_cnt_q  <= '0;
            dedup_cnt_q <= '0;
        end else begin
            cand_cnt_q  <= cand_cnt_d;
            dedup_cnt_q <= dedup_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_sketch_hot_page_filter.sv
// tb_sketch_hot_page_filter: randomized and directed checks against a queue-based reference model.
module tb_sketch_hot_page_filter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rd_data_in;
    logic [11:0] rd_addr_in;
    logic        rd_data_valid_in;
    logic [31:0] threshold;
    logic        dedup_clr;
    logic [11:0] hot_addr;
    logic [31:0] hot_cnt;
    logic        hot_valid;
    logic        hot_ready;
    logic [3:0]  fifo_level;
    logic [15:0] drop_cnt;
`ifdef HOT_FILTER_STATS_EN
    logic [31:0] cand_cnt;
    logic [15:0] dedup_cnt;
`endif

    sketch_hot_page_filter dut (
        .clk(clk), .rst(rst), .rd_data_in(rd_data_in), .rd_addr_in(rd_addr_in),
        .rd_data_valid_in(rd_data_valid_in), .threshold(threshold), .dedup_clr(dedup_clr),
        .hot_addr(hot_addr), .hot_cnt(hot_cnt), .hot_valid(hot_valid), .hot_ready(hot_ready),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt)
`ifdef HOT_FILTER_STATS_EN
        , .cand_cnt(cand_cnt), .dedup_cnt(dedup_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] c;
    } ent_t;

    ent_t        fq[$];
    logic [11:0] dq[$];
    logic        m_s1v;
    logic [11:0] m_s1a;
    logic [31:0] m_s1c;
    logic [15:0] m_drop, m_dd;
    logic [31:0] m_cand;
    int          nerr = 0;
    int          nchk = 0;
    logic [64:0] obs;

    assign obs = {hot_valid, hot_addr, hot_cnt, fifo_level, drop_cnt};

    // Reference: FIFO as a queue of candidates, dedup table as the last four accepted addresses since a clear.
    task automatic model_tick();
        bit hit, pop;
        if (rst) begin
            fq.delete(); dq.delete();
            m_s1v = 0; m_drop = 0; m_cand = 0; m_dd = 0;
            return;
        end
        pop = fq.size() != 0 && hot_ready;
        hit = 0;
        foreach (dq[i]) if (dq[i] == m_s1a) hit = 1;
        if (pop) void'(fq.pop_front());
        if (m_s1v) begin
            m_cand++;
            if (hit) begin
                if (m_dd != 16'hFFFF) m_dd++;
            end else if (fq.size() < 8) begin
                fq.push_back('{m_s1a, m_s1c});
                if (!dedup_clr) begin
                    dq.push_back(m_s1a);
                    if (dq.size() > 4) void'(dq.pop_front());
                end
            end else if (m_drop != 16'hFFFF) m_drop++;
        end
        if (dedup_clr) dq.delete();
        m_s1v = rd_data_valid_in && threshold != 0 && rd_data_in >= threshold;
        m_s1a = rd_addr_in;
        m_s1c = rd_data_in;
    endtask

    function automatic logic [64:0] exp_vec();
        ent_t h;
        h = fq.size() != 0 ? fq[0] : '0;
        return {fq.size() != 0, h.a, h.c, 4'(fq.size()), m_drop};
    endfunction

    task automatic step(input logic v, input logic [11:0] a, input logic [31:0] c);
        rd_data_valid_in = v;
        rd_addr_in = a;
        rd_data_in = c;
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic clr_pulse();
        dedup_clr = 1;
        step(0, 0, 0);
        dedup_clr = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        step(0, 0, 0);
        step(0, 0, 0);
        nchk++; if (obs !== 65'd0) begin nerr++; $display("FAIL reset_state: got %h exp 0", obs); end
        rst = 0;
    endtask

    task automatic test_basic();
        threshold = 10; hot_ready = 1;
        step(1, 12'h123, 10);
        nchk++; if (hot_valid !== 1'b0) begin nerr++; $display("FAIL basic_n1: hot_valid %b exp 0", hot_valid); end
        step(0, 0, 0);
        nchk++; if (obs !== {1'b1, 12'h123, 32'd10, 4'd1, 16'd0}) begin nerr++; $display("FAIL basic_n2: got %h", obs); end
        step(0, 0, 0);
        nchk++; if (hot_valid !== 1'b0) begin nerr++; $display("FAIL basic_one_cycle: hot_valid %b exp 0", hot_valid); end
        step(1, 12'h124, 9);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0);
            nchk++; if (hot_valid !== 1'b0) begin nerr++; $display("FAIL basic_below: hot_valid %b exp 0", hot_valid); end
        end
    endtask

    task automatic test_dedup();
        logic [11:0] ord [6];
        ord = '{12'h1, 12'h2, 12'h3, 12'h4, 12'h5, 12'h1};
        hot_ready = 0; threshold = 10;
        for (int i = 0; i < 3; i++) step(1, 12'h055, 20);
        step(0, 0, 0); step(0, 0, 0);
        nchk++; if (fifo_level !== 4'd1) begin nerr++; $display("FAIL dedup_repeat: level %0d exp 1", fifo_level); end
        clr_pulse();
        step(1, 12'h055, 20);
        step(0, 0, 0); step(0, 0, 0);
        nchk++; if (fifo_level !== 4'd2) begin nerr++; $display("FAIL dedup_clr: level %0d exp 2", fifo_level); end
        nchk++; if (obs !== exp_vec()) begin nerr++; $display("FAIL dedup_model: got %h exp %h", obs, exp_vec()); end
        hot_ready = 1;
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        clr_pulse();
        hot_ready = 0;
        for (int i = 1; i <= 5; i++) step(1, 12'(i), 20);
        step(1, 12'h1, 20);
        step(0, 0, 0); step(0, 0, 0);
        nchk++; if (fifo_level !== 4'd6) begin nerr++; $display("FAIL dedup_replace: level %0d exp 6", fifo_level); end
        hot_ready = 1;
        for (int k = 0; k < 6; k++) begin
            nchk++; if (hot_addr !== ord[k]) begin nerr++; $display("FAIL dedup_order%0d: addr %h exp %h", k, hot_addr, ord[k]); end
            step(0, 0, 0);
        end
    endtask

    task automatic test_full_drop();
        hot_ready = 0; threshold = 50;
        clr_pulse();
        for (int i = 0; i < 10; i++) step(1, 12'('h200 + i), 50);
        step(0, 0, 0); step(0, 0, 0);
        nchk++; if ({fifo_level, drop_cnt} !== {4'd8, 16'd2}) begin nerr++; $display("FAIL full_drop: level %0d drop %0d exp 8 2", fifo_level, drop_cnt); end
        hot_ready = 1;
        for (int k = 0; k < 8; k++) begin
            nchk++; if (hot_addr !== 12'('h200 + k)) begin nerr++; $display("FAIL drain_order%0d: addr %h", k, hot_addr); end
            step(0, 0, 0);
        end
        nchk++; if (fifo_level !== 4'd0) begin nerr++; $display("FAIL drain_empty: level %0d exp 0", fifo_level); end
        step(1, 12'h209, 50);
        step(1, 12'h207, 50);
        nchk++; if ({hot_valid, hot_addr} !== {1'b1, 12'h209}) begin nerr++; $display("FAIL dropped_not_in_table: got %b %h", hot_valid, hot_addr); end
        step(0, 0, 0);
        nchk++; if (hot_valid !== 1'b0) begin nerr++; $display("FAIL table_hit_after_drop: hot_valid %b exp 0", hot_valid); end
        step(0, 0, 0);
    endtask

    task automatic test_full_pop();
        hot_ready = 0; threshold = 5;
        clr_pulse();
        for (int i = 0; i < 8; i++) step(1, 12'('h300 + i), 77);
        step(1, 12'h310, 77);
        hot_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            step(1, 12'('h310 + i), 77);
            nchk++; if ({fifo_level, drop_cnt} !== {4'd8, 16'd2}) begin nerr++; $display("FAIL full_pop: level %0d drop %0d exp 8 2", fifo_level, drop_cnt); end
            nchk++; if (obs !== exp_vec()) begin nerr++; $display("FAIL full_pop_model: got %h exp %h", obs, exp_vec()); end
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0);
            nchk++; if (obs !== exp_vec()) begin nerr++; $display("FAIL full_pop_drain: got %h exp %h", obs, exp_vec()); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) threshold = $urandom_range(0, 40);
            hot_ready = 1'($urandom_range(0, 1));
            dedup_clr = $urandom_range(0, 31) == 0;
            step($urandom_range(0, 3) != 0, 12'($urandom_range(0, 15)), $urandom_range(0, 60));
            nchk++; if (obs !== exp_vec()) begin nerr++; $display("FAIL random%0d: got %h exp %h", n, obs, exp_vec()); end
`ifdef HOT_FILTER_STATS_EN
            nchk++; if ({cand_cnt, dedup_cnt} !== {m_cand, m_dd}) begin nerr++; $display("FAIL stats%0d: got %h %h exp %h %h", n, cand_cnt, dedup_cnt, m_cand, m_dd); end
`endif
        end
        dedup_clr = 0;
    endtask

    task automatic test_threshold_sat();
        hot_ready = 1;
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        threshold = 0;
        step(1, 12'h400, 32'hFFFFFFFF);
        step(0, 0, 0); step(0, 0, 0);
        nchk++; if ({hot_valid, fifo_level} !== {1'b0, 4'd0}) begin nerr++; $display("FAIL thresh_zero: valid %b level %0d exp 0 0", hot_valid, fifo_level); end
        threshold = 1; hot_ready = 0;
        clr_pulse();
        for (int i = 0; i < 8; i++) step(1, 12'('h500 + i), 5);
        for (int i = 0; i < 65540; i++) step(1, 12'h7FF, 5);
        step(0, 0, 0); step(0, 0, 0);
        nchk++; if ({fifo_level, drop_cnt} !== {4'd8, 16'hFFFF}) begin nerr++; $display("FAIL drop_sat: level %0d drop %h exp 8 ffff", fifo_level, drop_cnt); end
        nchk++; if (obs !== exp_vec()) begin nerr++; $display("FAIL sat_model: got %h exp %h", obs, exp_vec()); end
    endtask

    task automatic test_reset_mid();
        hot_ready = 1;
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        clr_pulse();
        hot_ready = 0;
        for (int i = 0; i < 6; i++) step(1, 12'('h600 + i), 9);
        nchk++; if (fifo_level !== 4'd5) begin nerr++; $display("FAIL pre_reset_level: level %0d exp 5", fifo_level); end
        rst = 1;
        step(0, 0, 0);
        nchk++; if (obs !== 65'd0) begin nerr++; $display("FAIL reset_mid: got %h exp 0", obs); end
        rst = 0;
        step(0, 0, 0);
        nchk++; if (obs !== 65'd0) begin nerr++; $display("FAIL reset_s1_flush: got %h exp 0", obs); end
        hot_ready = 1;
        step(1, 12'h600, 9);
        step(0, 0, 0);
        nchk++; if ({hot_valid, hot_addr, hot_cnt} !== {1'b1, 12'h600, 32'd9}) begin nerr++; $display("FAIL reset_table: got %b %h %0d", hot_valid, hot_addr, hot_cnt); end
    endtask

    initial begin
        rst = 1; rd_data_in = 0; rd_addr_in = 0; rd_data_valid_in = 0;
        threshold = 0; dedup_clr = 0; hot_ready = 0;
        test_reset();
        test_basic();
        test_dedup();
        test_full_drop();
        test_full_pop();
        test_random();
        test_threshold_sat();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
